adc_conversion_sequencer: RTL and testbench
===========================================

# adc_conversion_sequencer

Controller that sequences one analog-to-digital conversion on the 8-bit R2R DAC / external comparator loop. It drives the DAC code, waits a programmable settle time per step, samples the comparator through a synchronizer, and runs either a successive-approximation (SAR) or a linear-ramp search. It sits between the top-level mode/button logic, which issues `start` and `algorithm_sel`, and the `R2R_out` pins plus the `comp_r2r` pin. It replaces hand-timed bit stepping with a deterministic FSM.

## Interface
- `DATA_WIDTH`, 8, DAC code and result width.
- `SETTLE_CYCLES`, 6250, clock cycles per DAC step (62.5 us at 100 MHz). Must be ≥ 4.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `algorithm_sel` input 1: 0 = SAR, 1 = ramp. Latched at start.
- `continuous` input 1: when high at DONE, immediately begin the next conversion.
- `comp_in` input 1: raw comparator, asynchronous. 1 means Vin > Vdac.
- `dac_code` output DATA_WIDTH: code driven to the R2R ladder.
- `result` output DATA_WIDTH: last completed conversion. Held until the next completion.
- `result_valid` output 1: one-cycle pulse when `result` updates.
- `busy` output 1: high in SETTLE and DONE.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE → SETTLE on `start`. At the same edge:
  - latch `algorithm_sel`;
  - load settle counter = SETTLE_CYCLES−1;
  - SAR: `dac_code` = 0x80, bit index = 7.
  - Ramp: `dac_code` = 0x00.
- SETTLE decrements the counter each cycle. The decision is taken in the cycle where the counter is 0, using the synchronized comparator `comp_s`.
- SAR decision:
  - if `comp_s`=0, clear the current bit;
  - if index > 0, set the next lower bit, decrement index, reload the counter, stay in SETTLE;
  - if index = 0, write the final code to `result` and go to DONE.
- Ramp decision:
  - if `comp_s`=1 and code < 0xFF: increment code and reload the counter;
  - if `comp_s`=1 and code = 0xFF: result = 0xFF, go to DONE;
  - if `comp_s`=0: result = code−1 (0 if code = 0), go to DONE.
- DONE lasts one cycle with `result_valid`=1.
  - DONE → IDLE if `continuous`=0.
  - DONE → SETTLE (fresh start, re-latching `algorithm_sel`) if `continuous`=1.
- Ignored inputs:
  - `start` in SETTLE/DONE is ignored;
  - `algorithm_sel` changes mid-conversion are ignored.
- `dac_code` holds its final value in IDLE until the next start.
- Arithmetic is unsigned, DATA_WIDTH bits. Ramp increment never wraps (guarded at 0xFF) and decrement never underflows (guarded at 0).

## Timing
- Reset values (asynchronous, applied immediately, including mid-conversion):
  - state IDLE;
  - `dac_code`=0, `result`=0, `result_valid`=0, `busy`=0;
  - synchronizer flops=0, counter=0.
- `comp_in` passes through a 2-flop synchronizer. The decision at counter 0 therefore sees the comparator as of 2 cycles earlier, which is why SETTLE_CYCLES ≥ 4.
- With `start` sampled at edge T:
  - SAR: `result_valid` is high in cycle T+1+8·SETTLE_CYCLES.
  - Ramp with N decisions: `result_valid` is high in cycle T+1+N·SETTLE_CYCLES.
- Each DAC code is held for exactly SETTLE_CYCLES cycles.
- In continuous mode, the next conversion's first code appears the cycle after DONE.

## Configuration
- `ADC_SEQ_RAMP_EN` defined: the ramp algorithm is compiled in and `algorithm_sel` is honored.
- Undefined: ramp logic is removed, `algorithm_sel` is ignored, and every conversion is SAR.

## Structure
- Shared package `adc_ctrl_pkg` holds:
  - `seq_state_t` enum (IDLE, SETTLE, DONE);
  - `adc_alg_t` enum (ALG_SAR=0, ALG_RAMP=1);
  - `ADC_SETTLE_DEFAULT`=6250;
  - `ADC_DATA_WIDTH`=8.
- One sub-module: `comp_synchronizer`, a 2-flop synchronizer with async active-low reset.

## Test plan
Use SETTLE_CYCLES=4 for all scenarios.

- **SAR bit pattern.** Drive comparator decisions 1,1,0,1,1,0,1,0.
  - `dac_code` steps 0x80, 0xC0, 0xE0, 0xD0, 0xD8, 0xDC, 0xDA, 0xDB.
  - `result`=0xDA, with `result_valid` at T+33.
- **SAR extremes.** `comp_in` held 1 gives `result`=0xFF; held 0 gives `result`=0x00. Each is valid at T+33.
- **Ramp threshold** (`ADC_SEQ_RAMP_EN`). Model comp = (`dac_code` ≤ 5).
  - `result`=0x05 after 7 decisions, valid at T+29.
  - With comp held 1, `result`=0xFF valid at T+1+256·4.
- **Ignored inputs.** `start` pulses and `algorithm_sel` toggles during a SAR conversion have no effect: a single `result_valid`, same result as the undisturbed run.
- **Continuous mode.** `continuous`=1 gives back-to-back conversions: `result_valid` every 8·4+1 cycles and `dac_code`=0x80 the cycle after each DONE.
- **Reset mid-conversion.** Drive `reset` low at step 4.
  - All outputs read 0 asynchronously.
  - After release, the block stays IDLE with `busy`=0 until the next `start`.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// Shared types and defaults for the ADC conversion sequencer.
// Optional ramp search is controlled by ADC_SEQ_RAMP_EN.
package adc_ctrl_pkg;

  localparam int ADC_DATA_WIDTH     = 8;
  localparam int ADC_SETTLE_DEFAULT = 6250;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } seq_state_t;

  typedef enum logic {
    ALG_SAR  = 1'b0,
    ALG_RAMP = 1'b1
  } adc_alg_t;

endpackage

// File: rtl/comp_synchronizer.sv
// Two-flop synchronizer for the asynchronous comparator input.
// Both flops clear on an asynchronous active-low reset.
module comp_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_conversion_sequencer.sv
// SAR / linear-ramp conversion sequencer for the R2R DAC and comparator.
// Define ADC_SEQ_RAMP_EN to compile in the ramp search; default is SAR only.
module adc_conversion_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int SETTLE_CYCLES = ADC_SETTLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  algorithm_sel,
  input  logic                  continuous,
  input  logic                  comp_in,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MSB = ONE << IDX_TOP;

  seq_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] sar_code;
  logic                  launch;
  logic                  comp_s;
`ifdef ADC_SEQ_RAMP_EN
  adc_alg_t              alg_q, alg_d;
`endif

  comp_synchronizer u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (comp_in),
    .q     (comp_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dac_d    = dac_q;
    res_d    = res_q;
    launch   = 1'b0;
    sar_code = dac_q;
    if (!comp_s) sar_code[idx_q] = 1'b0;
`ifdef ADC_SEQ_RAMP_EN
    alg_d = alg_q;
`endif

    unique case (state_q)
      IDLE: launch = start;
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
`ifdef ADC_SEQ_RAMP_EN
        end else if (alg_q == ALG_RAMP) begin
          if (comp_s && dac_q != '1) begin
            dac_d = dac_q + ONE;
            cnt_d = CNT_LOAD;
          end else begin
            res_d = comp_s ? '1 :
                    (dac_q == '0) ? '0 : dac_q - ONE;
            state_d = DONE;
          end
`endif
        end else if (idx_q != '0) begin
          dac_d = sar_code | (ONE << (idx_q - IW'(1)));
          idx_d = idx_q - IW'(1);
          cnt_d = CNT_LOAD;
        end else begin
          dac_d   = sar_code;
          res_d   = sar_code;
          state_d = DONE;
        end
      end
      DONE: begin
        launch  = continuous;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Fresh conversion start, shared by IDLE+start and continuous DONE
    if (launch) begin
      state_d = SETTLE;
      cnt_d   = CNT_LOAD;
      idx_d   = IDX_TOP;
      dac_d   = MSB;
`ifdef ADC_SEQ_RAMP_EN
      alg_d = adc_alg_t'(algorithm_sel);
      if (algorithm_sel) dac_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      res_q   <= '0;
`ifdef ADC_SEQ_RAMP_EN
      alg_q   <= ALG_SAR;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
`ifdef ADC_SEQ_RAMP_EN
      alg_q   <= alg_d;
`endif
    end
  end

`ifndef ADC_SEQ_RAMP_EN
  logic unused_sel;
  assign unused_sel = algorithm_sel;
`endif

  assign dac_code     = dac_q;
  assign result       = res_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Directed bench for adc_conversion_sequencer with SETTLE_CYCLES=4.
// Ramp scenarios run only when ADC_SEQ_RAMP_EN is defined.
module tb_adc_conversion_sequencer;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       algorithm_sel;
  logic       continuous;
  logic       comp_in;
  logic [7:0] dac_code;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] vin;
  int         comp_mode;

  always #5 clk = ~clk;

  // Comparator model: 1 when Vin >= Vdac, or forced high/low
  always_comb begin
    case (comp_mode)
      1:       comp_in = 1'b1;
      2:       comp_in = 1'b0;
      default: comp_in = (dac_code <= vin);
    endcase
  end

  adc_conversion_sequencer #(
    .DATA_WIDTH    (8),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .algorithm_sel (algorithm_sel),
    .continuous    (continuous),
    .comp_in       (comp_in),
    .dac_code      (dac_code),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  task automatic do_start(input logic alg);
    @(negedge clk);
    algorithm_sel = alg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (result_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({dac_code, result, result_valid, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: got %h/%h/%b/%b expected 0",
               dac_code, result, result_valid, busy);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dac_code, result, result_valid, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_held: got %h/%h/%b/%b expected 0",
               dac_code, result, result_valid, busy);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_sar_pattern;
    logic [7:0] exp_code [8];
    exp_code = '{8'h80, 8'hC0, 8'hE0, 8'hD0,
                 8'hD8, 8'hDC, 8'hDA, 8'hDB};
    comp_mode = 0;
    vin = 8'hDA;
    do_start(1'b0);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (i % S == 1 && i <= 29) begin
        checks++;
        if (dac_code !== exp_code[(i - 1) / S]) begin
          errors++;
          $display("FAIL sar_step%0d: got %h expected %h",
                   (i - 1) / S, dac_code, exp_code[(i - 1) / S]);
        end
      end
      if (i == 4 || i == 32) begin
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL sar_busy_c%0d: got valid=%b busy=%b expected 0/1",
                   i, result_valid, busy);
        end
      end
      if (i == 33) begin
        checks++;
        if (result_valid !== 1'b1 || result !== 8'hDA) begin
          errors++;
          $display("FAIL sar_done: got valid=%b result=%h expected 1/da",
                   result_valid, result);
        end
      end
      if (i == 34) begin
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 ||
            dac_code !== 8'hDA || result !== 8'hDA) begin
          errors++;
          $display("FAIL sar_idle_hold: got v=%b b=%b dac=%h res=%h expected 0/0/da/da",
                   result_valid, busy, dac_code, result);
        end
      end
    end
  endtask

  task automatic test_sar_extremes;
    int n;
    comp_mode = 1;
    do_start(1'b0);
    wait_valid(n);
    checks++;
    if (n !== 33 || result !== 8'hFF) begin
      errors++;
      $display("FAIL sar_all_ones: got cycle=%0d result=%h expected 33/ff",
               n, result);
    end
    comp_mode = 2;
    do_start(1'b0);
    wait_valid(n);
    checks++;
    if (n !== 33 || result !== 8'h00) begin
      errors++;
      $display("FAIL sar_all_zeros: got cycle=%0d result=%h expected 33/00",
               n, result);
    end
    comp_mode = 0;
  endtask

  task automatic test_ignored_inputs;
    int nvalid;
    int first;
    logic [7:0] res;
    nvalid = 0;
    first = -1;
    res = 8'h00;
    vin = 8'h5A;
    do_start(1'b0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (result_valid) begin
        nvalid++;
        if (first < 0) begin
          first = i;
          res = result;
        end
      end
      start = (i == 5 || i == 13 || i == 20);
      algorithm_sel = i[0];
    end
    start = 1'b0;
    algorithm_sel = 1'b0;
    checks++;
    if (nvalid !== 1 || first !== 33 || res !== 8'h5A) begin
      errors++;
      $display("FAIL ignored_inputs: got n=%0d at=%0d res=%h expected 1/33/5a",
               nvalid, first, res);
    end
  endtask

  task automatic test_continuous;
    int n;
    vin = 8'h33;
    continuous = 1'b1;
    do_start(1'b0);
    wait_valid(n);
    checks++;
    if (n !== 33 || result !== 8'h33) begin
      errors++;
      $display("FAIL cont_first: got cycle=%0d result=%h expected 33/33",
               n, result);
    end
    vin = 8'h99;
    @(negedge clk);
    checks++;
    if (dac_code !== 8'h80 || busy !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL cont_restart: got dac=%h busy=%b v=%b expected 80/1/0",
               dac_code, busy, result_valid);
    end
    wait_valid(n);
    checks++;
    if (n !== 32 || result !== 8'h99) begin
      errors++;
      $display("FAIL cont_second: got cycle=%0d result=%h expected 32/99",
               n, result);
    end
    continuous = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dac_code !== 8'h99) begin
      errors++;
      $display("FAIL cont_stop: got busy=%b dac=%h expected 0/99",
               busy, dac_code);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int nvalid;
    vin = 8'hA5;
    do_start(1'b0);
    repeat (13) @(negedge clk);
    checks++;
    if (dac_code !== 8'hB0) begin
      errors++;
      $display("FAIL rst_mid_step3: got %h expected b0", dac_code);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dac_code, result, result_valid, busy} !== 18'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h/%h/%b/%b expected 0",
               dac_code, result, result_valid, busy);
    end
    #1 reset = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid || busy) nvalid++;
    end
    checks++;
    if (nvalid !== 0 || dac_code !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_idle: got active=%0d dac=%h expected 0/00",
               nvalid, dac_code);
    end
    do_start(1'b0);
    wait_valid(n);
    checks++;
    if (n !== 33 || result !== 8'hA5) begin
      errors++;
      $display("FAIL rst_mid_rerun: got cycle=%0d result=%h expected 33/a5",
               n, result);
    end
  endtask

`ifdef ADC_SEQ_RAMP_EN
  task automatic test_ramp;
    int n;
    comp_mode = 0;
    vin = 8'h05;
    do_start(1'b1);
    wait_valid(n);
    checks++;
    if (n !== 29 || result !== 8'h05) begin
      errors++;
      $display("FAIL ramp_threshold: got cycle=%0d result=%h expected 29/05",
               n, result);
    end
    comp_mode = 1;
    do_start(1'b1);
    wait_valid(n);
    checks++;
    if (n !== 1 + 256 * S || result !== 8'hFF) begin
      errors++;
      $display("FAIL ramp_full: got cycle=%0d result=%h expected %0d/ff",
               n, result, 1 + 256 * S);
    end
    comp_mode = 0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    start = 1'b0;
    algorithm_sel = 1'b0;
    continuous = 1'b0;
    comp_mode = 0;
    vin = 8'h00;
    test_reset;
    test_sar_pattern;
    test_sar_extremes;
    test_ignored_inputs;
    test_continuous;
    test_reset_mid;
`ifdef ADC_SEQ_RAMP_EN
    test_ramp;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
